// File: rtl/wrr_bus_scheduler.sv
// Weighted round-robin bus scheduler for four units, with per-unit credits,
// an ownership timeout and a one-cycle turnaround between owners.
module wrr_bus_scheduler #(
    parameter int WEIGHT_W = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic                  done,
    input  logic [4*WEIGHT_W-1:0] weight,
    output logic [3:0]            gnt,
    output logic [1:0]            gnt_id,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WEIGHT_W-1:0] credit_q [4];
    logic [WEIGHT_W-1:0] credit_d [4];
    logic [WEIGHT_W-1:0] eff_w    [4];
    logic [1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          gnt_q, gnt_d;
    logic [1:0]          gnt_id_q, gnt_id_d;
    logic                busy_q, busy_d;
    logic                terr_q, terr_d;

    logic [3:0]          eligible;
    logic [3:0]          cand;
    logic                reload;
    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic [1:0]          scan_idx;
    logic                normal_end;
    logic                timeout_hit;

    // When nobody eligible is requesting, credits refill and the raw requests
    // become the candidates, so a pick always exists whenever req != 0.
    always_comb begin
        eligible   = '0;
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        scan_idx   = '0;
        for (int i = 0; i < 4; i++) begin
            eff_w[i]    = weight[i*WEIGHT_W +: WEIGHT_W];
            if (eff_w[i] == '0) begin
                eff_w[i] = WEIGHT_W'(1);
            end
            eligible[i] = req[i] && (credit_q[i] != '0);
        end
        reload = (eligible == 4'b0000) && (req != 4'b0000);
        cand   = reload ? req : eligible;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!pick_valid && cand[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign normal_end  = done || !req[gnt_id_q];
    assign timeout_hit = (cnt_q == TIMEOUT_C) && !normal_end;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        terr_d   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            credit_d[i] = credit_q[i];
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    if (reload) begin
                        for (int i = 0; i < 4; i++) begin
                            credit_d[i] = eff_w[i];
                        end
                        credit_d[pick_idx] = eff_w[pick_idx] - WEIGHT_W'(1);
                    end else begin
                        credit_d[pick_idx] = credit_q[pick_idx] - WEIGHT_W'(1);
                    end
                    state_d  = OWN;
                    gnt_d    = 4'b0001 << pick_idx;
                    gnt_id_d = pick_idx;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            OWN: begin
                if (normal_end || timeout_hit) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = gnt_id_q + 2'd1;
                    if (timeout_hit) begin
                        terr_d             = 1'b1;
                        credit_d[gnt_id_q] = '0;
                    end
                end else if (cnt_q != TIMEOUT_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            terr_q   <= terr_d;
            for (int i = 0; i < 4; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_wrr_bus_scheduler.sv
// Bench for wrr_bus_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level reference model of the arbitration rules.
module tb_wrr_bus_scheduler;

    localparam int WEIGHT_W = 3;
    localparam int TIMEOUT  = 15;
    localparam int PH_IDLE  = 0;
    localparam int PH_OWN   = 1;
    localparam int PH_TURN  = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [3:0]            req = 4'b0000;
    logic                  done = 1'b0;
    logic [4*WEIGHT_W-1:0] wgt = 12'h249;
    logic [3:0]            gnt;
    logic [1:0]            gnt_id;
    logic                  busy;
    logic                  timeout_err;

    int checks = 0;
    int errors = 0;

    int mPhase;
    int mCredit [4];
    int mPtr;
    int mOwner;
    int mCount;
    bit mTerr;

    int grantOrder [$];
    bit prevBusy;
    int busyCnt;
    int terrCnt;

    int exp033 [5] = '{0, 1, 2, 3, 0};
    int exp034 [9] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};

    wrr_bus_scheduler #(
        .WEIGHT_W(WEIGHT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .weight     (wgt),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int effW(int u);
        int w;
        w = int'((wgt >> (u * WEIGHT_W)) & ((1 << WEIGHT_W) - 1));
        return (w == 0) ? 1 : w;
    endfunction

    task automatic modelReset();
        mPhase = PH_IDLE;
        mPtr   = 0;
        mOwner = 0;
        mCount = 0;
        mTerr  = 1'b0;
        for (int u = 0; u < 4; u++) mCredit[u] = 0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit anyElig;
        int win;
        int u;
        mTerr = 1'b0;
        if (mPhase == PH_IDLE) begin
            if (req != 4'b0000) begin
                anyElig = 1'b0;
                for (int i = 0; i < 4; i++) if (req[i] && mCredit[i] > 0) anyElig = 1'b1;
                if (!anyElig) for (int i = 0; i < 4; i++) mCredit[i] = effW(i);
                win = -1;
                for (int k = 0; k < 4; k++) begin
                    u = (mPtr + k) % 4;
                    if (win < 0 && req[u] && mCredit[u] > 0) win = u;
                end
                mCredit[win] = mCredit[win] - 1;
                mOwner = win;
                mCount = 0;
                mPhase = PH_OWN;
            end
        end else if (mPhase == PH_OWN) begin
            if (done || !req[mOwner]) begin
                mPhase = PH_TURN;
                mPtr   = (mOwner + 1) % 4;
            end else if (mCount == TIMEOUT) begin
                mPhase          = PH_TURN;
                mPtr            = (mOwner + 1) % 4;
                mTerr           = 1'b1;
                mCredit[mOwner] = 0;
            end else begin
                mCount++;
            end
        end else begin
            mPhase = PH_IDLE;
        end
    endtask

    task automatic checkOutput();
        bit expBusy;
        expBusy = (mPhase == PH_OWN);
        checkVal("gnt", 32'(gnt), expBusy ? 32'(4'b0001 << mOwner) : 32'd0);
        checkVal("busy", 32'(busy), 32'(expBusy));
        checkVal("timeout_err", 32'(timeout_err), 32'(mTerr));
        checkVal("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
        if (expBusy) checkVal("gnt_id", 32'(gnt_id), 32'(mOwner));
    endtask

    // Drives one cycle of inputs (from a falling edge), then checks at the next falling edge.
    task automatic applyStimulus(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
        if (busy && !prevBusy) grantOrder.push_back(int'(gnt_id));
        prevBusy = busy;
    endtask

    task automatic doReset();
        req  = 4'b0000;
        done = 1'b0;
        rst  = 1'b0;
        modelReset();
        repeat (2) begin
            @(negedge clk);
            checkOutput();
        end
        checkVal("rst_gnt_id", 32'(gnt_id), 32'd0);
        rst      = 1'b1;
        prevBusy = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        logic       d;
        modelReset();
        prevBusy = 1'b0;

        $display("[TB] reset state");
        @(negedge clk);
        doReset();

        $display("[TB] single request and done");
        applyStimulus(4'b0001, 1'b0);
        checkVal("req032_gnt", 32'(gnt), 32'h1);
        applyStimulus(4'b0001, 1'b1);
        checkVal("req032_release", 32'(gnt), 32'h0);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);

        $display("[TB] equal weights rotation");
        doReset();
        grantOrder.delete();
        repeat (15) applyStimulus(4'b1111, 1'b1);
        for (int i = 0; i < 5; i++)
            checkVal($sformatf("req033_order%0d", i),
                     (i < grantOrder.size()) ? 32'(grantOrder[i]) : 32'd99, 32'(exp033[i]));

        $display("[TB] 3:1 weighting");
        doReset();
        wgt = 12'h24B;
        grantOrder.delete();
        repeat (27) applyStimulus(4'b0011, 1'b1);
        for (int i = 0; i < 9; i++)
            checkVal($sformatf("req034_order%0d", i),
                     (i < grantOrder.size()) ? 32'(grantOrder[i]) : 32'd99, 32'(exp034[i]));

        $display("[TB] ownership timeout");
        doReset();
        wgt = 12'h249;
        applyStimulus(4'b0100, 1'b0);
        busyCnt = busy ? 1 : 0;
        terrCnt = timeout_err ? 1 : 0;
        repeat (16) begin
            applyStimulus(4'b0100, 1'b0);
            busyCnt += busy ? 1 : 0;
            terrCnt += timeout_err ? 1 : 0;
        end
        repeat (2) begin
            applyStimulus(4'b0000, 1'b0);
            busyCnt += busy ? 1 : 0;
            terrCnt += timeout_err ? 1 : 0;
        end
        checkVal("req035_own_cycles", 32'(busyCnt), 32'd16);
        checkVal("req035_terr_cycles", 32'(terrCnt), 32'd1);
        applyStimulus(4'b0110, 1'b0);
        checkVal("req035_skip", 32'(gnt), 32'h2);
        repeat (4) applyStimulus(4'b0110, 1'b1);

        $display("[TB] done coincides with timeout");
        doReset();
        applyStimulus(4'b1000, 1'b0);
        repeat (15) applyStimulus(4'b1000, 1'b0);
        checkVal("req036_own16", 32'(busy), 32'd1);
        applyStimulus(4'b1000, 1'b1);
        checkVal("req036_busy", 32'(busy), 32'd0);
        checkVal("req036_terr", 32'(timeout_err), 32'd0);
        applyStimulus(4'b0000, 1'b0);

        $display("[TB] asynchronous reset mid-ownership");
        doReset();
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0);
        #2 rst = 1'b0;
        #1;
        checkVal("req037_gnt", 32'(gnt), 32'h0);
        checkVal("req037_busy", 32'(busy), 32'd0);
        modelReset();
        @(negedge clk);
        rst      = 1'b1;
        prevBusy = 1'b0;
        applyStimulus(4'b1111, 1'b0);
        checkVal("req037_restart", 32'(gnt), 32'h1);
        applyStimulus(4'b1111, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        $display("[TB] random traffic");
        r = 4'b0000;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 49) == 0) wgt = 12'($urandom);
            if ($urandom_range(0, 5) == 0) r = 4'($urandom);
            d = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) doReset();
            applyStimulus(r, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wrr_bus_scheduler.md
WRR_BUS_SCHEDULER -- requirements
Module: wrr_bus_scheduler

Interface
REQ-001 Parameter: WEIGHT_W, default 3, width of each per-requester weight field.
REQ-002 Parameter: TIMEOUT, default 15, maximum ownership cycles before forced release.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  request from units 3..0; bit i high = unit i wants the bus.
REQ-006 done  input  1  current owner finished its transaction; sampled only in OWN.
REQ-007 weight  input  4*WEIGHT_W  per-unit weights, unit i at bits [i*WEIGHT_W +: WEIGHT_W]; sampled only at credit reload.
REQ-008 gnt  output  4  one-hot grant, registered.
REQ-009 gnt_id  output  2  encoded index of the granted unit, registered; valid while busy=1.
REQ-010 busy  output  1  high while any grant is held (state OWN).
REQ-011 timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have three states: IDLE, OWN, TURN.
REQ-013 Each unit SHALL have a credit counter, WEIGHT_W bits wide; eff_weight(i) = weight(i), or 1 if weight(i)=0.
REQ-014 The block SHALL compute eligible = req & (credit != 0) in IDLE.
REQ-015 In IDLE with eligible != 0, the block SHALL pick the first eligible unit scanning ptr, ptr+1, ... modulo 4.
REQ-016 In IDLE with req != 0 and eligible == 0, the block SHALL reload every credit to eff_weight and pick the first requesting unit from ptr in the same cycle.
REQ-017 On a pick, the block SHALL go to OWN on the next edge with gnt/gnt_id/busy set, giving 1-cycle request-to-grant latency.
REQ-018 On a pick, the winner's credit SHALL decrement by 1, applied after any reload in that cycle.
REQ-019 In IDLE with req == 0, the block SHALL hold all state.
REQ-020 In OWN, an ownership counter SHALL clear on entry and increment each OWN cycle, saturating at TIMEOUT.
REQ-021 OWN SHALL end normally on a cycle where done=1 or req[owner]=0; on the next edge go to TURN, with gnt=0 and busy=0.
REQ-022 OWN SHALL end by timeout when the counter equals TIMEOUT and the normal-end condition is false; on the next edge go to TURN, pulse timeout_err=1 for that one cycle, and set the owner's credit to 0.
REQ-023 If done and the timeout condition coincide, done SHALL win: normal release, no timeout_err.
REQ-024 On either release, ptr SHALL become (owner+1) mod 4.
REQ-025 TURN SHALL last exactly one cycle with no grant (bus turnaround), then go to IDLE; requests in TURN are not arbitrated.
REQ-026 Requests from non-owners during OWN SHALL be ignored, with no preemption.
REQ-027 At most one gnt bit SHALL be high in any cycle, and gnt_id SHALL equal the index of that bit.
REQ-028 Credit arithmetic SHALL never wrap below 0: decrement of a zero credit is impossible by construction.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout_err=0, ptr=0, all credits=0, ownership counter=0.
REQ-030 Reset asserted during OWN SHALL drop gnt immediately, without waiting for a clock.
REQ-031 After reset release, the first request SHALL trigger a credit reload (REQ-016).

Verification
REQ-032 Reset release, req=4'b0001, all weights 1 -> gnt=4'b0001 one cycle later; done pulse -> gnt=0 next cycle, TURN 1 cycle, IDLE.
REQ-033 req=4'b1111 held, done pulsed every OWN cycle, weights all 1 -> grant order 0,1,2,3,0, each OWN followed by a 1-cycle TURN.
REQ-034 req=4'b0011 held, weight0=3, weight1=1, done each cycle -> order 0,1,0,0,1,0,0,... (3:1 ratio over each reload period).
REQ-035 Owner 2 holds req, done=0, TIMEOUT=15 -> release after 16 OWN cycles, timeout_err high exactly 1 cycle, unit 2 skipped until the next reload.
REQ-036 done=1 on the same cycle the counter reaches TIMEOUT -> normal release, timeout_err stays 0.
REQ-037 rst driven low mid-OWN between clock edges -> gnt=0 and busy=0 immediately; after release ptr=0 and arbitration restarts from unit 0.
